// File: rtl/dct_block_serializer_if.sv
// Handshake bundle for dct_block_serializer:
// 8-lane column beats in, one serial sample per cycle out.
interface dct_block_serializer_if #(
  parameter int DATA_W = 12
);
  logic              i_valid;
  logic              o_in_ready;
  logic [DATA_W-1:0] i_data0;
  logic [DATA_W-1:0] i_data1;
  logic [DATA_W-1:0] i_data2;
  logic [DATA_W-1:0] i_data3;
  logic [DATA_W-1:0] i_data4;
  logic [DATA_W-1:0] i_data5;
  logic [DATA_W-1:0] i_data6;
  logic [DATA_W-1:0] i_data7;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              i_out_ready;
  logic              o_last;

  modport master (
    output i_valid, i_out_ready,
    output i_data0, i_data1, i_data2, i_data3,
    output i_data4, i_data5, i_data6, i_data7,
    input  o_in_ready, o_data, o_valid, o_last
  );

  modport slave (
    input  i_valid, i_out_ready,
    input  i_data0, i_data1, i_data2, i_data3,
    input  i_data4, i_data5, i_data6, i_data7,
    output o_in_ready, o_data, o_valid, o_last
  );
endinterface

// File: rtl/dct_block_serializer.sv
// Ping-pong 8x8 block buffer: column beats in, serial samples out.
// Define DCT_ZIGZAG_EN for JPEG zigzag read order (default row-major).
module dct_block_serializer #(
  parameter int DATA_W = 12
) (
  input logic                  i_clk,
  input logic                  i_rst,
  dct_block_serializer_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY,
    FILL,
    FULL,
    DRAIN
  } bank_e;

  bank_e             st_q [2];
  bank_e             st_d [2];
  logic              wb_q;
  logic              rb_q;
  logic [2:0]        c_q;
  logic [5:0]        n_q;
  logic [DATA_W-1:0] mem_q [2][8][8];
  logic [DATA_W-1:0] lane [8];
  logic              in_rdy;
  logic              out_vld;
  logic              wr;
  logic              rd;
  logic [5:0]        pos;

  assign lane[0] = bus.i_data0;
  assign lane[1] = bus.i_data1;
  assign lane[2] = bus.i_data2;
  assign lane[3] = bus.i_data3;
  assign lane[4] = bus.i_data4;
  assign lane[5] = bus.i_data5;
  assign lane[6] = bus.i_data6;
  assign lane[7] = bus.i_data7;

  assign in_rdy  = (st_q[wb_q] == EMPTY)
                || (st_q[wb_q] == FILL);
  assign out_vld = (st_q[rb_q] == FULL)
                || (st_q[rb_q] == DRAIN);
  assign wr = bus.i_valid && in_rdy;
  assign rd = out_vld && bus.i_out_ready;

`ifdef DCT_ZIGZAG_EN
  // read index -> raster position (row*8+col)
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };
  assign pos = ZZ[n_q];
`else
  assign pos = n_q;
`endif

  // write and read always target different banks
  always_comb begin
    st_d[0] = st_q[0];
    st_d[1] = st_q[1];
    if (wr) begin
      unique case (1'b1)
        (c_q == 3'd0): st_d[wb_q] = FILL;
        (c_q == 3'd7): st_d[wb_q] = FULL;
        default: ;
      endcase
    end
    if (rd) begin
      unique case (1'b1)
        (n_q == 6'd0):  st_d[rb_q] = DRAIN;
        (n_q == 6'd63): st_d[rb_q] = EMPTY;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      st_q[0] <= EMPTY;
      st_q[1] <= EMPTY;
      wb_q    <= 1'b0;
      rb_q    <= 1'b0;
      c_q     <= 3'd0;
      n_q     <= 6'd0;
    end else begin
      st_q[0] <= st_d[0];
      st_q[1] <= st_d[1];
      wb_q    <= wb_q ^ (wr && (c_q == 3'd7));
      rb_q    <= rb_q ^ (rd && (n_q == 6'd63));
      c_q     <= c_q + {2'b0, wr};
      n_q     <= n_q + {5'b0, rd};
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr) begin
      for (int r = 0; r < 8; r++) begin
        mem_q[wb_q][r][c_q] <= lane[r];
      end
    end
  end

  assign bus.o_in_ready = in_rdy;
  assign bus.o_valid    = out_vld;
  assign bus.o_last     = out_vld && (n_q == 6'd63);
  assign bus.o_data     = out_vld
                        ? mem_q[rb_q][pos[5:3]][pos[2:0]]
                        : '0;

endmodule

// File: tb/tb_dct_block_serializer.sv
// Randomized bench for dct_block_serializer with a queue-based
// block model; DCT_ZIGZAG_EN selects the expected read order.
module tb_dct_block_serializer;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          vld = 1'b0;
  logic          ordy = 1'b0;
  logic [DW-1:0] lane_d [8];
  int            rdy_mode = 0;
  bit            chk_en = 0;
  int            errors = 0;
  int            checks = 0;
  int            taken = 0;

  dct_block_serializer_if #(.DATA_W(DW)) bus();

  dct_block_serializer #(.DATA_W(DW)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  assign bus.i_valid     = vld;
  assign bus.i_out_ready = ordy;
  assign bus.i_data0     = lane_d[0];
  assign bus.i_data1     = lane_d[1];
  assign bus.i_data2     = lane_d[2];
  assign bus.i_data3     = lane_d[3];
  assign bus.i_data4     = lane_d[4];
  assign bus.i_data5     = lane_d[5];
  assign bus.i_data6     = lane_d[6];
  assign bus.i_data7     = lane_d[7];

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // expected output order as raster positions
  int order [64];
  initial begin
`ifdef DCT_ZIGZAG_EN
    int k;
    k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo, hi;
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 1) begin
        for (int r = lo; r <= hi; r++) begin
          order[k] = r * 8 + (s - r);
          k++;
        end
      end else begin
        for (int r = hi; r >= lo; r--) begin
          order[k] = r * 8 + (s - r);
          k++;
        end
      end
    end
`else
    for (int k = 0; k < 64; k++) order[k] = k;
`endif
  end

  typedef struct {
    logic [DW-1:0] d;
    bit            last;
  } smp_t;

  smp_t          q [$];
  logic [DW-1:0] blk [8][8];
  int            col = 0;

  function automatic int pending();
    return (q.size() + 63) / 64;
  endfunction

  // model: complete blocks queue up as 64 samples each
  always @(posedge clk) begin : model
    bit m_rdy;
    bit m_vld;
    m_rdy = pending() < 2;
    m_vld = q.size() > 0;
    if (!rst) begin
      q.delete();
      col = 0;
    end else begin
      if (m_vld && ordy) void'(q.pop_front());
      if (vld && m_rdy) begin
        for (int r = 0; r < 8; r++) blk[r][col] = lane_d[r];
        col++;
        if (col == 8) begin
          col = 0;
          for (int k = 0; k < 64; k++) begin
            smp_t s;
            s.d    = blk[order[k] / 8][order[k] % 8];
            s.last = (k == 63);
            q.push_back(s);
          end
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    if (chk_en) begin
      bit            ev;
      logic [DW-1:0] ed;
      ev = q.size() > 0;
      ed = ev ? q[0].d : '0;
      chk("o_valid", bus.o_valid, ev);
      chk("o_in_ready", bus.o_in_ready, pending() < 2);
      chk("o_data", bus.o_data, ed);
      chk("o_last", bus.o_last, ev && q[0].last);
    end
  end

  always @(negedge clk) begin
    if (bus.o_valid && ordy) taken++;
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: ordy = 1'b0;
      1: ordy = 1'b1;
      default: ordy = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic put_block(input int base, input bit rnd);
    for (int c = 0; c < 8; c++) begin
      int w;
      @(negedge clk);
      vld = 1'b1;
      for (int r = 0; r < 8; r++) begin
        lane_d[r] = rnd ? DW'($urandom) : DW'(base + r * 8 + c);
      end
      w = 0;
      while (!bus.o_in_ready && w < 400) begin
        @(negedge clk);
        w++;
      end
      if (w >= 400) chk("beat_wait", 32'(w), 0);
    end
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (bus.o_valid && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("drain_wait", 32'(w < 2000), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    for (int r = 0; r < 8; r++) lane_d[r] = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_ready", bus.o_in_ready, 1);
    chk("rst_data", bus.o_data, 0);
    chk("rst_last", bus.o_last, 0);
    rst = 1'b1;
    chk_en = 1;

    // single ramp block, ready held high
    rdy_mode = 1;
    repeat (2) @(negedge clk);
    taken = 0;
    put_block(0, 0);
    chk("t1_lat_valid", bus.o_valid, 1);
    chk("t1_s0", bus.o_data, 0);
    repeat (2) @(negedge clk);
`ifdef DCT_ZIGZAG_EN
    chk("t1_s2", bus.o_data, 8);
`else
    chk("t1_s2", bus.o_data, 2);
`endif
    repeat (60) @(negedge clk);
    chk("t1_last_early", bus.o_last, 0);
    @(negedge clk);
    chk("t1_last", bus.o_last, 1);
    chk("t1_s63", bus.o_data, 63);
    repeat (2) @(negedge clk);
    chk("t1_done_valid", bus.o_valid, 0);
    chk("t1_taken", 32'(taken), 64);

    // random data under random backpressure
    rdy_mode = 2;
    repeat (2) @(negedge clk);
    taken = 0;
    put_block(0, 1);
    wait_drain();
    @(negedge clk);
    chk("t2_taken", 32'(taken), 64);

    // fill stall: only two blocks fit
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    acc = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      vld = 1'b1;
      for (int r = 0; r < 8; r++) lane_d[r] = DW'(500 + k * 8 + r);
      if (bus.o_in_ready) acc++;
    end
    @(negedge clk);
    vld = 1'b0;
    chk("t3_accepted", 32'(acc), 16);
    chk("t3_ready_low", bus.o_in_ready, 0);
    taken = 0;
    rdy_mode = 1;
    put_block(1000, 0);
    wait_drain();
    @(negedge clk);
    chk("t3_taken", 32'(taken), 192);

    // beat 7 and sample 63 on the same edge
    put_block(2000, 0);
    repeat (55) @(negedge clk);
    put_block(3000, 0);
    chk("t4_valid", bus.o_valid, 1);
    chk("t4_s0", bus.o_data, 3000);
    chk("t4_ready", bus.o_in_ready, 1);
    wait_drain();

    // reset while draining sample 20
    put_block(0, 0);
    repeat (20) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_valid", bus.o_valid, 0);
    chk("t5_data", bus.o_data, 0);
    chk("t5_ready", bus.o_in_ready, 1);
    chk("t5_last", bus.o_last, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    taken = 0;
    put_block(0, 0);
    chk("t5_s0", bus.o_data, 0);
    wait_drain();
    @(negedge clk);
    chk("t5_taken", 32'(taken), 64);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
